instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: assembles one- or two-word instructions from a byte-wide
// memory port and presents them to the group decoders with a valid/ready handshake.
// Optional feature macro: INSTR_FETCH_ILLEGAL_DETECT_EN (flags illegal group encodings).
// Ports:
//   clk, rst_n (synchronous, active-low)         - clock and reset
//   pc_load, pc_in[15:0]                         - redirect strobe and target byte address
//   mem_rd_req, mem_addr[15:0]                   - byte read request, held until acked
//   mem_rd_ack, mem_rd_data[7:0]                 - read completion and returned byte
//   instr_hi, instr_lo, instr_addr [15:0]        - assembled instruction and its address
//   instr_valid / instr_ready                    - presentation handshake
//   instr_illegal                                - unrecognised group encoding, qualified by instr_valid
module instr_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic        mem_rd_req,
  output logic [15:0] mem_addr,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rd_data,
  output logic [15:0] instr_hi,
  output logic [15:0] instr_lo,
  output logic [15:0] instr_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        instr_illegal
);

  typedef enum logic [2:0] {
    FETCH_HI0,
    FETCH_HI1,
    FETCH_LO0,
    FETCH_LO1,
    PRESENT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] fetch_pc;
  logic [15:0] hi_word;
  logic        group5;
  logic        take;

  // First word as it will look once the HI1 byte is stored.
  assign hi_word  = {instr_hi[15:8], mem_rd_data};
  assign group5   = (hi_word[15:10] == 6'b111000);
  // A redirect wins over a coincident ack, so that byte is dropped.
  assign take     = mem_rd_ack && (state != PRESENT) && !pc_load;
  assign mem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH_HI0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_rd_req  = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH_HI0: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) state_nxt = FETCH_HI1;
      end
      FETCH_HI1: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) state_nxt = group5 ? FETCH_LO0 : PRESENT;
      end
      FETCH_LO0: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) state_nxt = FETCH_LO1;
      end
      FETCH_LO1: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) state_nxt = PRESENT;
      end
      PRESENT: begin
        instr_valid = 1'b1;
        // Acceptance always returns through FETCH_HI0, giving one bubble cycle.
        if (instr_ready) state_nxt = FETCH_HI0;
      end
      default: state_nxt = FETCH_HI0;
    endcase
    // Redirect applies after any same-cycle handshake has completed.
    if (pc_load) state_nxt = FETCH_HI0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc   <= 16'h0000;
      instr_hi   <= 16'h0000;
      instr_lo   <= 16'h0000;
      instr_addr <= 16'h0000;
    end else if (pc_load) begin
      fetch_pc <= pc_in;
    end else if (take) begin
      fetch_pc <= fetch_pc + 16'd1;
      case (state)
        FETCH_HI0: begin
          instr_hi[15:8] <= mem_rd_data;
          instr_addr     <= fetch_pc;
        end
        FETCH_HI1: begin
          instr_hi[7:0] <= mem_rd_data;
          if (!group5) instr_lo <= 16'h0000;
        end
        FETCH_LO0: instr_lo[15:8] <= mem_rd_data;
        FETCH_LO1: instr_lo[7:0]  <= mem_rd_data;
        default: ;
      endcase
    end
  end

`ifdef INSTR_FETCH_ILLEGAL_DETECT_EN
  logic illegal_q;
  logic illegal_nxt;

  // Illegal encodings never match group 5, so they always present as single-word.
  assign illegal_nxt = (hi_word[15:12] == 4'b1111) ||
                       ((hi_word[15:12] == 4'b1110) && (hi_word[11:10] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (take && (state == FETCH_HI1)) begin
      illegal_q <= illegal_nxt;
    end
  end

  assign instr_illegal = instr_valid && illegal_q;
`else
  assign instr_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_load;
  logic [15:0] pc_in;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_rd_ack;
  logic [7:0]  mem_rd_data;
  logic [15:0] instr_hi;
  logic [15:0] instr_lo;
  logic [15:0] instr_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic        instr_illegal;

  logic [7:0]  mem [0:65535];
  logic        ack_en;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        exp_ill;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_load       (pc_load),
    .pc_in         (pc_in),
    .mem_rd_req    (mem_rd_req),
    .mem_addr      (mem_addr),
    .mem_rd_ack    (mem_rd_ack),
    .mem_rd_data   (mem_rd_data),
    .instr_hi      (instr_hi),
    .instr_lo      (instr_lo),
    .instr_addr    (instr_addr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_illegal (instr_illegal)
  );

  always #5 clk = ~clk;

  // Memory responder: acks any pending request in the same cycle.
  initial begin
    mem_rd_ack  = 1'b0;
    mem_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      mem_rd_ack  = ack_en && mem_rd_req;
      mem_rd_data = mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step();
    chk(tag, {15'd0, instr_valid}, 16'd1);
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] target);
    pc_load = 1'b1;
    pc_in   = target;
    step();
    pc_load = 1'b0;
  endtask

  initial begin
`ifdef INSTR_FETCH_ILLEGAL_DETECT_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0000] = 8'h12; mem[16'h0001] = 8'h34;
    mem[16'h0010] = 8'hE0; mem[16'h0011] = 8'h1F;
    mem[16'h0012] = 8'hAB; mem[16'h0013] = 8'hCD;
    mem[16'h0014] = 8'h11; mem[16'h0015] = 8'h22;
    mem[16'h0100] = 8'h56; mem[16'h0101] = 8'h57;
    mem[16'hFFFF] = 8'h9A;
    mem[16'h0200] = 8'hF0; mem[16'h0201] = 8'h00;
    mem[16'h0202] = 8'hE4; mem[16'h0203] = 8'h00;

    rst_n = 1'b0; pc_load = 1'b0; pc_in = 16'h0000;
    instr_ready = 1'b0; ack_en = 1'b0;
    step(); step();
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_hi", instr_hi, 16'h0000);
    chk("rst_addr", instr_addr, 16'h0000);
    chk("rst_ill", {15'd0, instr_illegal}, 16'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_req", {15'd0, mem_rd_req}, 16'd1);
    chk("post_rst_maddr", mem_addr, 16'h0000);
    ack_en = 1'b1;

    // Plain two-byte instruction at 0x0000.
    wait_valid("t1_valid");
    chk("t1_hi", instr_hi, 16'h1234);
    chk("t1_lo", instr_lo, 16'h0000);
    chk("t1_addr", instr_addr, 16'h0000);
    chk("t1_req", {15'd0, mem_rd_req}, 16'd0);
    accept();
    chk("t1_next_maddr", mem_addr, 16'h0002);
    chk("t1_bubble_valid", {15'd0, instr_valid}, 16'd0);

    // Redirect to a group-5 two-word instruction.
    redirect(16'h0010);
    chk("t2_maddr", mem_addr, 16'h0010);
    wait_valid("t2_valid");
    chk("t2_hi", instr_hi, 16'hE01F);
    chk("t2_lo", instr_lo, 16'hABCD);
    chk("t2_addr", instr_addr, 16'h0010);
    chk("t2_ill", {15'd0, instr_illegal}, 16'd0);

    // Stall for five cycles: everything must hold.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {15'd0, instr_valid}, 16'd1);
      chk("stall_hi", instr_hi, 16'hE01F);
      chk("stall_lo", instr_lo, 16'hABCD);
      chk("stall_req", {15'd0, mem_rd_req}, 16'd0);
    end
    accept();
    chk("t3_maddr", mem_addr, 16'h0014);
    chk("t3_req", {15'd0, mem_rd_req}, 16'd1);

    // HI0 at 0x0014 acks now; redirect lands on the HI1 ack.
    step();
    chk("t4_in_hi1_maddr", mem_addr, 16'h0015);
    redirect(16'h0100);
    chk("t4_maddr", mem_addr, 16'h0100);
    chk("t4_valid", {15'd0, instr_valid}, 16'd0);
    wait_valid("t4_valid2");
    chk("t4_hi", instr_hi, 16'h5657);
    chk("t4_addr", instr_addr, 16'h0100);

    // Address wrap: 0xFFFF then 0x0000.
    accept();
    redirect(16'hFFFF);
    wait_valid("t5_valid");
    chk("t5_hi", instr_hi, 16'h9A12);
    chk("t5_addr", instr_addr, 16'hFFFF);
    accept();
    chk("t5_next_maddr", mem_addr, 16'h0001);

    // Illegal encodings, single-word.
    redirect(16'h0200);
    wait_valid("t6_valid");
    chk("t6_hi", instr_hi, 16'hF000);
    chk("t6_lo", instr_lo, 16'h0000);
    chk("t6_ill", {15'd0, instr_illegal}, {15'd0, exp_ill});
    accept();
    chk("t6_ill_after", {15'd0, instr_illegal}, 16'd0);
    wait_valid("t7_valid");
    chk("t7_hi", instr_hi, 16'hE400);
    chk("t7_lo", instr_lo, 16'h0000);
    chk("t7_addr", instr_addr, 16'h0202);
    chk("t7_ill", {15'd0, instr_illegal}, {15'd0, exp_ill});

    // Reset mid-fetch.
    accept();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t8_maddr", mem_addr, 16'h0000);
    chk("t8_req", {15'd0, mem_rd_req}, 16'd1);
    chk("t8_hi", instr_hi, 16'h0000);
    chk("t8_valid", {15'd0, instr_valid}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
